// File: rtl/ad9361_seq_engine.sv
// ad9361_seq_engine: table-driven SPI register sequencer for AD9361 bring-up.
// Walks a synchronous command ROM (WRITE / masked POLL with retry / DELAY / END)
// and drives the ad936_spi_drv request/busy handshake.
// Build option: define AD9361_SEQ_WRITE_VERIFY_EN to read back and compare
// every WRITE under its mask (mask 0x00 means 0xFF).
module ad9361_seq_engine #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DEPTH    = 2600,
    parameter int unsigned NFLAG    = 16,
    parameter int unsigned DLY_DIV  = 20000,
    parameter int unsigned POLL_MAX = 1000,
    parameter int unsigned POLL_GAP = 20000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [9:0]        spi_addr,
    output logic [7:0]        spi_wdata,
    output logic              spi_req,
    output logic              spi_wr_rdn,
    input  logic [7:0]        spi_rdata,
    input  logic              spi_rdata_vld,
    input  logic              spi_busy,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err,
    output logic [ADDR_W-1:0] err_idx,
    output logic [NFLAG-1:0]  flags
);
    localparam int unsigned ATT_W = $clog2(POLL_MAX + 1);
    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int unsigned DIV_W = (DLY_DIV > 1) ? $clog2(DLY_DIV) : 1;

    typedef enum logic [1:0] {OP_WRITE, OP_POLL, OP_DELAY, OP_END} op_t;
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_ACK, S_RDWAIT,
        S_CHECK, S_GAP, S_DELAY, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
    logic [31:0]       cmd_q, cmd_d;
    logic [NFLAG-1:0]  flags_q, flags_d;
    logic              done_q, done_d, err_q, err_d;
    logic [ATT_W-1:0]  att_q, att_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [25:0]       tick_q, tick_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        cmp_mask;
    logic              rd_match;
    logic              issuing;
    op_t               cmd_op;
`ifdef AD9361_SEQ_WRITE_VERIFY_EN
    logic              vfy_q, vfy_d;
`endif

    assign cmd_op   = op_t'(cmd_q[31:30]);
    assign issuing  = (state_q == S_ISSUE) || (state_q == S_ACK);
    assign rom_addr = idx_q;
    assign spi_addr  = issuing ? cmd_q[25:16] : '0;
    assign spi_wdata = issuing ? cmd_q[7:0]   : '0;
    // Request drops combinationally the cycle the driver reports busy.
    assign spi_req  = (state_q == S_ACK) && !spi_busy;
`ifdef AD9361_SEQ_WRITE_VERIFY_EN
    assign spi_wr_rdn = issuing && (cmd_op == OP_WRITE) && !vfy_q;
`else
    assign spi_wr_rdn = issuing && (cmd_op == OP_WRITE);
`endif
    assign seq_busy = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign seq_done = done_q;
    assign seq_err  = err_q;
    assign err_idx  = err_idx_q;
    assign flags    = flags_q;

    // Masked compare of the latched read data against the command's expected byte.
    always_comb begin
        cmp_mask = cmd_q[15:8];
`ifdef AD9361_SEQ_WRITE_VERIFY_EN
        if (vfy_q && (cmp_mask == '0)) cmp_mask = '1;
`endif
        rd_match = (rdata_q & cmp_mask) == (cmd_q[7:0] & cmp_mask);
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        cmd_d     = cmd_q;
        flags_d   = flags_q;
        done_d    = done_q;
        err_d     = err_q;
        att_d     = att_q;
        gap_d     = gap_q;
        div_d     = div_q;
        tick_d    = tick_q;
        rdata_d   = rdata_q;
`ifdef AD9361_SEQ_WRITE_VERIFY_EN
        vfy_d     = vfy_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_FETCH;
                    idx_d     = '0;
                    err_idx_d = '0;
                    flags_d   = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    att_d     = '0;
`ifdef AD9361_SEQ_WRITE_VERIFY_EN
                    vfy_d     = 1'b0;
`endif
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                cmd_d = rom_data;
                case (op_t'(rom_data[31:30]))
                    OP_WRITE, OP_POLL: state_d = S_ISSUE;
                    OP_DELAY: begin
                        tick_d  = rom_data[25:0];
                        div_d   = '0;
                        state_d = (rom_data[25:0] == '0) ? S_NEXT : S_DELAY;
                    end
                    default: begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_ISSUE: if (!spi_busy) state_d = S_ACK;
            S_ACK: begin
                if (spi_busy) begin
`ifdef AD9361_SEQ_WRITE_VERIFY_EN
                    if ((cmd_op == OP_POLL) || vfy_q) state_d = S_RDWAIT;
                    else begin
                        vfy_d   = 1'b1;
                        state_d = S_ISSUE;
                    end
`else
                    state_d = (cmd_op == OP_POLL) ? S_RDWAIT : S_NEXT;
`endif
                end
            end
            S_RDWAIT: begin
                if (spi_rdata_vld) begin
                    rdata_d = spi_rdata;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef AD9361_SEQ_WRITE_VERIFY_EN
                if (vfy_q) begin
                    vfy_d = 1'b0;
                    if (rd_match) state_d = S_NEXT;
                    else begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = S_ERR;
                    end
                end else
`endif
                if (rd_match) begin
                    for (int unsigned i = 0; i < NFLAG; i++) begin
                        if (32'(cmd_q[29:26]) == i) flags_d[i] = 1'b1;
                    end
                    att_d   = '0;
                    state_d = S_NEXT;
                end else if (32'(att_q) + 32'd1 >= POLL_MAX) begin
                    att_d     = att_q + ATT_W'(1);
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    state_d   = S_ERR;
                end else begin
                    att_d   = att_q + ATT_W'(1);
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (32'(gap_q) == POLL_GAP - 1) begin
                    gap_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_DELAY: begin
                if (32'(div_q) == DLY_DIV - 1) begin
                    div_d = '0;
                    if (tick_q == 26'd1) state_d = S_NEXT;
                    else tick_d = tick_q - 26'd1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_NEXT: begin
                if (32'(idx_q) + 32'd1 == DEPTH) begin
                    err_d     = 1'b1;
                    err_idx_d = ADDR_W'(DEPTH - 1);
                    state_d   = S_ERR;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            err_idx_q <= '0;
            cmd_q     <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            att_q     <= '0;
            gap_q     <= '0;
            div_q     <= '0;
            tick_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            cmd_q     <= cmd_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            err_q     <= err_d;
            att_q     <= att_d;
            gap_q     <= gap_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef AD9361_SEQ_WRITE_VERIFY_EN
    // Marks the readback phase that follows each WRITE.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) vfy_q <= 1'b0;
        else         vfy_q <= vfy_d;
    end
`endif

endmodule

// File: doc/ad9361_seq_engine.md
Name: ad9361_seq_engine

Overview:
- Table-driven SPI register sequencer for the AD9361 bring-up path. It replaces hard-coded index checks with a command ROM of encoded operations: write, masked poll with timeout, delay, and end.
- It sits between a synchronous command ROM and the existing ad936_spi_drv handshake.
- It exposes per-checkpoint calibration flags, plus done and error status, to the top level.

Parameters:
- ADDR_W, 12, command ROM address width.
- DEPTH, 2600, number of valid ROM entries (must be ≤ 2**ADDR_W).
- NFLAG, 16, number of status flags a poll can set (≤ 16).
- DLY_DIV, 20000, clock cycles per delay tick (1 ms at 20 MHz).
- POLL_MAX, 1000, poll attempts before timeout error.
- POLL_GAP, 20000, idle cycles between poll attempts.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins the sequence at entry 0.
- rom_addr  out  ADDR_W  command ROM address.
- rom_data  in  32  command word; valid 1 cycle after rom_addr.
- spi_addr  out  10  register address to the driver.
- spi_wdata  out  8  write data to the driver.
- spi_req  out  1  request valid (driver data_in_en).
- spi_wr_rdn  out  1  1 = write, 0 = read.
- spi_rdata  in  8  read data from the driver.
- spi_rdata_vld  in  1  read data valid pulse.
- spi_busy  in  1  driver busy.
- seq_busy  out  1  sequence running.
- seq_done  out  1  END reached; sticky.
- seq_err  out  1  poll timeout, verify mismatch or table overrun; sticky.
- err_idx  out  ADDR_W  entry index that caused seq_err.
- flags  out  NFLAG  calibration checkpoint flags.

Behaviour:
- Reset values: all outputs 0; state IDLE; index 0; all counters 0.
- Command word layout:
  - [31:30] opcode: 00 WRITE, 01 POLL, 10 DELAY, 11 END.
  - [29:26] flag index; [25:16] register address; [15:8] mask; [7:0] data or expected value.
  - DELAY uses [25:0] as the tick count.
- States: IDLE, FETCH, DECODE, ISSUE, ACK, RDWAIT, CHECK, GAP, DELAY, NEXT, DONE, ERR.
- IDLE: on start → clear flags, seq_done, seq_err and index; go to FETCH. seq_busy = 1 in every state except IDLE, DONE and ERR.
- FETCH: drive rom_addr = index; one wait cycle; latch rom_data in DECODE.
- ISSUE (WRITE/POLL): wait for !spi_busy, then assert spi_req with addr, data and wr_rdn. spi_req stays high until spi_busy is seen (ACK state), then drops the same cycle.
  - WRITE → NEXT directly; the next ISSUE waits for !spi_busy.
- POLL: ACK → RDWAIT until spi_rdata_vld → CHECK.
  - Match when (spi_rdata & mask) == (expected & mask).
  - On match: set flags[flag index] (ignored if ≥ NFLAG), clear the attempt counter, go to NEXT.
  - On mismatch: increment attempts. When attempts reaches POLL_MAX → ERR; otherwise GAP for exactly POLL_GAP cycles, then ISSUE again.
- DELAY: stay exactly N×DLY_DIV cycles, then NEXT. N = 0 → NEXT on the following cycle.
- END → DONE with seq_done = 1.
- NEXT: index + 1. If index + 1 == DEPTH with no END executed → ERR, err_idx = DEPTH-1.
- ERR: seq_err = 1, err_idx = failing index, flags hold their values.
- start is ignored while seq_busy. start in DONE or ERR restarts from IDLE semantics.
- sys_rst mid-operation aborts immediately. spi_req drops asynchronously and the driver's in-flight transfer completes unobserved.
- spi_rdata_vld arriving outside RDWAIT is ignored.

Optional Feature:
- Macro: AD9361_SEQ_WRITE_VERIFY_EN.
- Defined: after each WRITE, the engine issues a read of the same address and compares it under mask. Mask 0x00 is treated as 0xFF. Mismatch → ERR with err_idx = that entry; no retry.
- Undefined: WRITE goes straight to NEXT, and the verify logic is absent.

Test Plan:
- ROM {WRITE 0x3DF=0x01, WRITE 0x2A6=0x0E, END}, driver model 8-cycle busy → two spi_req pulses with the correct addr/data, then seq_done = 1, seq_err = 0, flags = 0.
- POLL 0x037 mask 0x08 exp 0x08 flag 0; model returns 0x00 twice then 0x08 → exactly 3 reads, each pair of reads separated by ≥ POLL_GAP cycles, flags[0] = 1, done.
- POLL with a model that always returns 0x00, POLL_MAX = 4 → exactly 4 reads, seq_err = 1, err_idx = entry index, seq_done = 0.
- DELAY 3 ticks with DLY_DIV = 10 → 30 cycles between the preceding and following spi_req; DELAY 0 → no stall beyond fetch.
- sys_rst asserted during RDWAIT → all outputs 0 next edge. A later start reruns from entry 0; a start pulse mid-run has no effect.
- Verify build: model corrupts the readback of 0x2A6 (0x0F) → seq_err = 1, err_idx = 1. Non-verify build: same stimulus → seq_done = 1.
